// File: rtl/fnd_out_display.sv
// rtl/fnd_out_display.sv - 8-bit value to 3-digit BCD, scanned onto a 4-digit common-anode FND
//
// Purpose: accepts one unsigned byte through a valid/ready handshake, converts it to BCD
// with an 8-step sequential shift-add-3 engine, and continuously multiplexes the latched
// hundreds/tens/ones onto a 4-digit active-low 7-segment display with leading-zero blanking.
//
// Ports:
//   clk       in  1  system clock, all state on the rising edge
//   rst       in  1  asynchronous active-low reset
//   in_data   in  8  value to display (0..255)
//   in_valid  in  1  in_data presented for capture
//   in_ready  out 1  high while idle and able to accept a value
//   fnd_com   out 4  active-low digit enables, bit 0 = rightmost digit
//   fnd_font  out 8  active-low segments {dp,g,f,e,d,c,b,a}

module fnd_out_display #(
  parameter int SCAN_DIV = 100_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [3:0] fnd_com,
  output logic [7:0] fnd_font
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic          w_accept;
  logic          w_last;

  logic [7:0]    r_shift;
  logic [11:0]   r_bcd;
  logic [2:0]    r_cnt;
  logic [3:0]    r_hund;
  logic [3:0]    r_tens;
  logic [3:0]    r_ones;
  logic [PW-1:0] r_presc;
  logic [1:0]    r_sel;

  logic [11:0]   w_adj;
  logic [11:0]   w_bcd_next;
  logic [3:0]    w_digit;
  logic          w_blank;

  function automatic logic [7:0] font(input logic [3:0] d);
    case (d)
      4'd0:    font = 8'hC0;
      4'd1:    font = 8'hF9;
      4'd2:    font = 8'hA4;
      4'd3:    font = 8'hB0;
      4'd4:    font = 8'h99;
      4'd5:    font = 8'h92;
      4'd6:    font = 8'h82;
      4'd7:    font = 8'hF8;
      4'd8:    font = 8'h80;
      4'd9:    font = 8'h90;
      default: font = 8'hFF;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_accept     = 1'b1;
          w_state_next = CONV;
        end
      end
      CONV: begin
        if (r_cnt == 3'd7) begin
          w_last       = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign in_ready = (r_state == IDLE);

  // Add-3 correction per nibble before the shift, so the shift itself does the
  // decimal carry into the next nibble.
  assign w_adj[3:0]   = (r_bcd[3:0]   >= 4'd5) ? r_bcd[3:0]   + 4'd3 : r_bcd[3:0];
  assign w_adj[7:4]   = (r_bcd[7:4]   >= 4'd5) ? r_bcd[7:4]   + 4'd3 : r_bcd[7:4];
  assign w_adj[11:8]  = (r_bcd[11:8]  >= 4'd5) ? r_bcd[11:8]  + 4'd3 : r_bcd[11:8];
  assign w_bcd_next   = {w_adj[10:0], r_shift[7]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shift <= 8'd0;
      r_bcd   <= 12'd0;
      r_cnt   <= 3'd0;
      r_hund  <= 4'd0;
      r_tens  <= 4'd0;
      r_ones  <= 4'd0;
    end else if (w_accept) begin
      r_shift <= in_data;
      r_bcd   <= 12'd0;
      r_cnt   <= 3'd0;
    end else if (r_state == CONV) begin
      r_shift <= {r_shift[6:0], 1'b0};
      r_bcd   <= w_bcd_next;
      r_cnt   <= r_cnt + 3'd1;
      // Display registers take the post-shift result of the final step, so the
      // old value stays visible for the whole conversion.
      if (w_last) begin
        r_hund <= w_bcd_next[11:8];
        r_tens <= w_bcd_next[7:4];
        r_ones <= w_bcd_next[3:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_presc <= '0;
      r_sel   <= 2'd0;
    end else if (r_presc == PRESC_MAX) begin
      r_presc <= '0;
      r_sel   <= r_sel + 2'd1;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  // Leading-zero blanking: tens hides only when hundreds is also zero, so inner
  // zeros such as in 100 remain visible.
  always_comb begin
    w_digit = 4'd0;
    w_blank = 1'b1;
    case (r_sel)
      2'd0: begin
        w_digit = r_ones;
        w_blank = 1'b0;
      end
      2'd1: begin
        w_digit = r_tens;
        w_blank = (r_hund == 4'd0) && (r_tens == 4'd0);
      end
      2'd2: begin
        w_digit = r_hund;
        w_blank = (r_hund == 4'd0);
      end
      default: begin
        w_digit = 4'd0;
        w_blank = 1'b1;
      end
    endcase
  end

  assign fnd_com  = ~(4'b0001 << r_sel);
  assign fnd_font = w_blank ? 8'hFF : font(w_digit);

endmodule

// File: tb/tb_fnd_out_display.sv
// tb/tb_fnd_out_display.sv - directed self-checking bench for fnd_out_display

module tb_fnd_out_display;

  logic       clk;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] fnd_com;
  logic [7:0] fnd_font;

  int n_checks = 0;
  int n_fail   = 0;

  fnd_out_display #(.SCAN_DIV(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .fnd_com  (fnd_com),
    .fnd_font (fnd_font)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] seg(input int d);
    case (d)
      0: seg = 8'hC0;  1: seg = 8'hF9;  2: seg = 8'hA4;  3: seg = 8'hB0;  4: seg = 8'h99;
      5: seg = 8'h92;  6: seg = 8'h82;  7: seg = 8'hF8;  8: seg = 8'h80;  9: seg = 8'h90;
      default: seg = 8'hFF;
    endcase
  endfunction

  // Expected {d3,d2,d1,d0} fonts for a displayed value.
  function automatic logic [3:0][7:0] exp_disp(input int v);
    int h, t, o;
    h = v / 100;
    t = (v / 10) % 10;
    o = v % 10;
    exp_disp[0] = seg(o);
    exp_disp[1] = (h == 0 && t == 0) ? 8'hFF : seg(t);
    exp_disp[2] = (h == 0) ? 8'hFF : seg(h);
    exp_disp[3] = 8'hFF;
  endfunction

  function automatic int com_idx(input logic [3:0] c);
    case (c)
      4'b1110: com_idx = 0;
      4'b1101: com_idx = 1;
      4'b1011: com_idx = 2;
      4'b0111: com_idx = 3;
      default: com_idx = -1;
    endcase
  endfunction

  // Called at a negedge; returns at a negedge with the fonts seen on each digit.
  task automatic capture(output logic [3:0][7:0] f, output bit ok);
    logic [3:0] seen;
    int k;
    seen = 4'h0;
    f = '0;
    for (int c = 0; c < 24 && seen != 4'hF; c++) begin
      @(negedge clk);
      k = com_idx(fnd_com);
      if (k >= 0) begin
        f[k] = fnd_font;
        seen[k] = 1'b1;
      end
    end
    ok = (seen == 4'hF);
  endtask

  // Called at a negedge; waits for ready, presents v for one edge, and counts
  // the negedges with in_ready low until it returns high.
  task automatic send(input logic [7:0] v, output int low_cnt, output bit ok);
    int w;
    ok = 1'b0;
    low_cnt = 0;
    for (w = 0; w < 30 && !in_ready; w++) @(negedge clk);
    if (in_ready) begin
      in_data  = v;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      for (w = 0; w < 30 && !in_ready; w++) begin
        low_cnt++;
        @(negedge clk);
      end
      ok = in_ready;
    end
  endtask

  task automatic send_and_check(input logic [7:0] v, input logic [3:0][7:0] expd, input string name);
    int lc;
    bit ok, cok;
    logic [3:0][7:0] f;
    send(v, lc, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s handshake: in_ready never returned (got %0d low cycles), required 8", name, lc);
    end
    capture(f, cok);
    n_checks++;
    if (!cok || f !== expd) begin
      n_fail++;
      $display("FAIL %s digits: got %h (complete=%0d), required %h", name, f, cok, expd);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'($urandom);
      in_data  = 8'($urandom);
      @(negedge clk);
      n_checks++;
      if (fnd_com !== 4'b1110 || fnd_font !== 8'hC0 || in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_state: com=%b font=%h ready=%b, required 1110 C0 1", fnd_com, fnd_font, in_ready);
      end
    end
    in_valid = 1'b0;
    in_data  = 8'h00;
    rst = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      logic [3:0] ec;
      logic [7:0] ef;
      int s;
      @(negedge clk);
      s  = (n / 4) % 4;
      ec = ~(4'b0001 << s);
      ef = (s == 0) ? 8'hC0 : 8'hFF;
      n_checks++;
      if (fnd_com !== ec || fnd_font !== ef) begin
        n_fail++;
        $display("FAIL scan_edge%0d: com=%b font=%h, required %b %h", n, fnd_com, fnd_font, ec, ef);
      end
    end
  endtask

  task automatic test_send_55();
    int lc;
    bit ok, cok;
    logic [3:0][7:0] f;
    send(8'd55, lc, ok);
    n_checks++;
    if (!ok || lc != 8) begin
      n_fail++;
      $display("FAIL ready_low_len: got %0d cycles (ok=%0d), required 8", lc, ok);
    end
    capture(f, cok);
    n_checks++;
    if (!cok || f !== {8'hFF, 8'hFF, 8'h92, 8'h92}) begin
      n_fail++;
      $display("FAIL send_55: got %h (complete=%0d), required ffff9292", f, cok);
    end
  endtask

  task automatic test_values();
    send_and_check(8'd255, {8'hFF, 8'hA4, 8'h92, 8'h92}, "send_255");
    send_and_check(8'd100, {8'hFF, 8'hF9, 8'hC0, 8'hC0}, "send_100");
    send_and_check(8'd7,   {8'hFF, 8'hFF, 8'hFF, 8'hF8}, "send_7");
  endtask

  task automatic test_back_to_back();
    logic [3:0][7:0] f;
    logic [3:0][7:0] e12;
    bit cok;
    int k;
    e12 = {8'hFF, 8'hFF, 8'hF9, 8'hA4};
    in_data  = 8'd12;
    in_valid = 1'b1;
    @(negedge clk);
    in_data = 8'd34;
    repeat (7) @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_busy: in_ready=%b after 7 steps, required 0", in_ready);
    end
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_finish_edge: in_ready=%b after conversion, required 1", in_ready);
    end
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 1) begin
        in_valid = 1'b0;
        n_checks++;
        if (in_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_second_accept: in_ready=%b, required 0", in_ready);
        end
      end
      k = com_idx(fnd_com);
      n_checks++;
      if (k < 0 || fnd_font !== e12[k]) begin
        n_fail++;
        $display("FAIL b2b_show12: com=%b font=%h, required digit font of 12", fnd_com, fnd_font);
      end
    end
    for (int w = 0; w < 30 && !in_ready; w++) @(negedge clk);
    capture(f, cok);
    n_checks++;
    if (!cok || f !== {8'hFF, 8'hFF, 8'hB0, 8'h99}) begin
      n_fail++;
      $display("FAIL b2b_show34: got %h (complete=%0d), required ffffb099", f, cok);
    end
  endtask

  task automatic test_reset_mid_conv();
    logic [3:0][7:0] f;
    bit cok;
    for (int w = 0; w < 30 && !in_ready; w++) @(negedge clk);
    in_data  = 8'd200;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || fnd_com !== 4'b1110 || fnd_font !== 8'hC0) begin
      n_fail++;
      $display("FAIL abort_state: ready=%b com=%b font=%h, required 1 1110 C0", in_ready, fnd_com, fnd_font);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (12) @(negedge clk);
    capture(f, cok);
    n_checks++;
    if (!cok || f !== {8'hFF, 8'hFF, 8'hFF, 8'hC0}) begin
      n_fail++;
      $display("FAIL abort_display: got %h (complete=%0d), required ffffffc0", f, cok);
    end
  endtask

  task automatic test_sweep();
    int lc;
    bit ok, cok;
    logic [3:0][7:0] f;
    for (int v = 0; v < 256; v++) begin
      send(8'(v), lc, ok);
      capture(f, cok);
      n_checks++;
      if (!ok || !cok || f !== exp_disp(v)) begin
        n_fail++;
        $display("FAIL sweep_%0d: got %h (ok=%0d/%0d), required %h", v, f, ok, cok, exp_disp(v));
      end
    end
  endtask

  initial begin
    rst      = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    @(negedge clk);
    test_reset();
    test_send_55();
    test_values();
    test_back_to_back();
    test_reset_mid_conv();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
